// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared types and widths for the logic sweep sequencer.
package logic_sweep_ctrl_pkg;

   localparam int unsigned VecW = 4;
   localparam int unsigned TtW  = 16;
   localparam int unsigned CntW = 8;
   localparam int unsigned ErrW = 5;

   localparam logic [VecW-1:0] LastVec = 4'hF;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StSample = 2'd2,
      StDone   = 2'd3
   } state_e;

endpackage

// File: rtl/logic_sweep_ctrl_settle_timer.sv
// Settle interval counter: counts up while enabled, flags the last settle cycle.
module logic_sweep_ctrl_settle_timer
   import logic_sweep_ctrl_pkg::*;
#(
   parameter int unsigned Limit = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LastCnt);

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Walks all 16 input vectors of a 4-input logic block, samples y after a settle
// interval and compares the measured truth table against a latched expected table.
module logic_sweep_ctrl
   import logic_sweep_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [TtW-1:0]  exp_tt,
   input  logic            y,
   output logic            a,
   output logic            b,
   output logic            c,
   output logic            d,
   output logic            busy,
   output logic            done,
   output logic [TtW-1:0]  tt,
   output logic            pass,
   output logic [ErrW-1:0] err_cnt,
   output logic            fail_valid,
   output logic [VecW-1:0] first_fail
);

   state_e            state_q, state_d;
   logic [VecW-1:0]   idx_q, idx_d;
   logic [TtW-1:0]    exp_q, exp_d;
   logic [TtW-1:0]    tt_q, tt_d;
   logic [ErrW-1:0]   err_q, err_d;
   logic              fv_q, fv_d;
   logic [VecW-1:0]   ff_q, ff_d;
   logic              pass_q, pass_d;
   logic              busy_q, busy_d;

   logic              tmr_clr;
   logic              tmr_inc;
   logic              tmr_expire;
   logic              accept;
   logic              mismatch;
   logic              last_vec;

   logic_sweep_ctrl_settle_timer #(
      .Limit (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (tmr_clr),
      .inc_i    (tmr_inc),
      .expire_o (tmr_expire)
   );

   // Counter runs only in SETTLE; every other state leaves it cleared for the next vector.
   assign tmr_clr  = (state_q != StSettle);
   assign tmr_inc  = (state_q == StSettle) && !tmr_expire;
   assign accept   = (state_q == StIdle) && start && !abort;
   assign mismatch = y ^ exp_q[idx_q];
   assign last_vec = (idx_q == LastVec);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StSettle;
         end
         StSettle: begin
            if (abort)           state_d = StIdle;
            else if (tmr_expire) state_d = StSample;
         end
         StSample: begin
            if (abort)         state_d = StIdle;
            else if (last_vec) state_d = StDone;
            else               state_d = StSettle;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      idx_d  = idx_q;
      exp_d  = exp_q;
      tt_d   = tt_q;
      err_d  = err_q;
      fv_d   = fv_q;
      ff_d   = ff_q;
      pass_d = pass_q;
      busy_d = busy_q;

      if (accept) begin
         exp_d  = exp_tt;
         idx_d  = '0;
         tt_d   = '0;
         err_d  = '0;
         fv_d   = 1'b0;
         ff_d   = '0;
         pass_d = 1'b0;
         busy_d = 1'b1;
      end else if (abort && (state_q != StIdle)) begin
         // Partial results stay visible for debug; only the drive and status reset.
         idx_d  = '0;
         pass_d = 1'b0;
         busy_d = 1'b0;
      end else if (state_q == StSample) begin
         tt_d[idx_q] = y;
         if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fv_q) begin
               fv_d = 1'b1;
               ff_d = idx_q;
            end
         end
         if (last_vec) begin
            busy_d = 1'b0;
            pass_d = (err_q == '0) && !mismatch;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         exp_q  <= '0;
         tt_q   <= '0;
         err_q  <= '0;
         fv_q   <= 1'b0;
         ff_q   <= '0;
         pass_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         exp_q  <= exp_d;
         tt_q   <= tt_d;
         err_q  <= err_d;
         fv_q   <= fv_d;
         ff_q   <= ff_d;
         pass_q <= pass_d;
         busy_q <= busy_d;
      end
   end

   // Outputs
   always_comb begin
      {a, b, c, d} = idx_q;
      done         = (state_q == StDone);
      busy         = busy_q;
      tt           = tt_q;
      pass         = pass_q;
      err_cnt      = err_q;
      fail_valid   = fv_q;
      first_fail   = ff_q;
   end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Scoreboard bench: two sequencers (settle 2 and settle 1) drive modelled logic blocks.
module tb_logic_sweep_ctrl;

   localparam int unsigned S0 = 2;
   localparam int unsigned S1 = 1;

   localparam int ModeAnd = 0;
   localparam int ModeXor = 1;
   localparam int ModeOr  = 2;
   localparam int ModeOne = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start0, abort0, y0, a0, b0, c0, d0, busy0, done0, pass0, fv0;
   logic [15:0] exp0, tt0;
   logic [4:0]  ec0;
   logic [3:0]  ff0;
   logic        start1, abort1, y1, a1, b1, c1, d1, busy1, done1, pass1, fv1;
   logic [15:0] exp1, tt1;
   logic [4:0]  ec1;
   logic [3:0]  ff1;
   int          mode0, mode1;

   function automatic logic blk(input int m, input logic [3:0] v);
      case (m)
         ModeAnd: return &v;
         ModeXor: return ^v;
         ModeOr:  return |v;
         default: return 1'b1;
      endcase
   endfunction

   assign y0 = blk(mode0, {a0, b0, c0, d0});
   assign y1 = blk(mode1, {a1, b1, c1, d1});

   logic_sweep_ctrl #(.SETTLE_CYCLES(S0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .exp_tt(exp0), .y(y0),
      .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .tt(tt0),
      .pass(pass0), .err_cnt(ec0), .fail_valid(fv0), .first_fail(ff0)
   );

   logic_sweep_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .exp_tt(exp1), .y(y1),
      .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .tt(tt1),
      .pass(pass1), .err_cnt(ec1), .fail_valid(fv1), .first_fail(ff1)
   );

   typedef struct {
      logic [15:0] tt;
      logic        pass;
      logic [4:0]  ec;
      logic        fv;
      logic [3:0]  ff;
      int          k;
      int          lat;
      string       name;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic pd0 = 1'b0;
   logic pd1 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic score(input exp_t e, input logic [15:0] t, input logic p, input logic [4:0] ec,
                        input logic fv, input logic [3:0] ff, input logic bz);
      check({e.name, "_tt"}, 64'(t), 64'(e.tt));
      check({e.name, "_pass"}, 64'(p), 64'(e.pass));
      check({e.name, "_err_cnt"}, 64'(ec), 64'(e.ec));
      check({e.name, "_fail_valid"}, 64'(fv), 64'(e.fv));
      if (e.fv) check({e.name, "_first_fail"}, 64'(ff), 64'(e.ff));
      check({e.name, "_latency"}, 64'(cyc - e.k), 64'(e.lat));
      check({e.name, "_busy_in_done"}, 64'(bz), 64'd0);
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (done0) begin
         check("done0_one_cycle", 64'(pd0), 64'd0);
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done0: got done=1 required no done");
         end else begin
            e = q0.pop_front();
            score(e, tt0, pass0, ec0, fv0, ff0, busy0);
         end
      end
      if (done1) begin
         check("done1_one_cycle", 64'(pd1), 64'd0);
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done1: got done=1 required no done");
         end else begin
            e = q1.pop_front();
            score(e, tt1, pass1, ec1, fv1, ff1, busy1);
         end
      end
      pd0 <= done0;
      pd1 <= done1;
   end

   task automatic go(input int which, input int m, input logic [15:0] e, input bit push,
                     input logic [15:0] ett, input logic ep, input logic [4:0] eec,
                     input logic efv, input logic [3:0] eff, input string nm);
      exp_t x;
      @(negedge clk);
      if (which == 0) begin
         mode0 = m; exp0 = e; start0 = 1'b1;
      end else begin
         mode1 = m; exp1 = e; start1 = 1'b1;
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      check({nm, "_busy_after_start"}, 64'((which == 0) ? busy0 : busy1), 64'd1);
      x.tt = ett; x.pass = ep; x.ec = eec; x.fv = efv; x.ff = eff;
      x.k = cyc; x.lat = 16 * (int'((which == 0) ? S0 : S1) + 1); x.name = nm;
      if (push) begin
         if (which == 0) q0.push_back(x);
         else            q1.push_back(x);
      end
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      @(posedge clk);
      #1;
      if (q0.size() != 0 || q1.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d pending required 0", nm, q0.size() + q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   task automatic wait_vec0(input logic [3:0] v, input string nm);
      int n;
      n = 0;
      while ({a0, b0, c0, d0} != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_reach_vec"}, 64'({a0, b0, c0, d0}), 64'(v));
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; exp0 = '0; mode0 = ModeAnd;
      start1 = 1'b0; abort1 = 1'b0; exp1 = '0; mode1 = ModeAnd;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({a0, b0, c0, d0, busy0, done0, tt0, pass0, ec0, fv0, ff0}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // XOR4 on the settle-1 instance: 32-edge sweep.
      go(1, ModeXor, 16'h6996, 1, 16'h6996, 1'b1, 5'd0, 1'b0, 4'd0, "xor_s1");
      wait_idle("xor_s1");

      go(0, ModeAnd, 16'h8000, 1, 16'h8000, 1'b1, 5'd0, 1'b0, 4'd0, "and4");
      wait_idle("and4");
      check("and4_pass_held", 64'(pass0), 64'd1);

      go(0, ModeOr, 16'hFFFF, 1, 16'hFFFE, 1'b0, 5'd1, 1'b1, 4'd0, "or4");
      wait_idle("or4");

      go(0, ModeAnd, 16'h0000, 1, 16'h8000, 1'b0, 5'd1, 1'b1, 4'd15, "and4_last_fail");
      wait_idle("and4_last_fail");

      go(0, ModeOne, 16'h0000, 1, 16'hFFFF, 1'b0, 5'd16, 1'b1, 4'd0, "all_fail");
      wait_idle("all_fail");

      // Mid-sweep start pulse and expected-table change must both be ignored.
      go(0, ModeXor, 16'h6996, 1, 16'h6996, 1'b1, 5'd0, 1'b0, 4'd0, "latched_exp");
      repeat (10) @(posedge clk);
      @(negedge clk);
      start0 = 1'b1;
      exp0 = 16'h0000;
      @(negedge clk);
      start0 = 1'b0;
      wait_idle("latched_exp");

      // Abort at vector 5: vectors 0..4 of XOR4 already sampled.
      go(0, ModeXor, 16'h6996, 0, 16'h0, 1'b0, 5'd0, 1'b0, 4'd0, "abort");
      wait_vec0(4'd5, "abort");
      abort0 = 1'b1;
      @(posedge clk);
      #1;
      abort0 = 1'b0;
      check("abort_vec", 64'({a0, b0, c0, d0}), 64'd0);
      check("abort_busy_done", 64'({busy0, done0}), 64'd0);
      check("abort_partial_tt", 64'(tt0), 64'h0016);
      check("abort_pass_err", 64'({pass0, ec0}), 64'd0);
      repeat (60) @(posedge clk);
      go(0, ModeXor, 16'h6996, 1, 16'h6996, 1'b1, 5'd0, 1'b0, 4'd0, "after_abort");
      wait_idle("after_abort");

      // Abort and start together in IDLE: start must not be accepted.
      @(negedge clk);
      start0 = 1'b1;
      abort0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      abort0 = 1'b0;
      check("abort_start_busy", 64'(busy0), 64'd0);
      check("abort_start_tt_kept", 64'(tt0), 64'h6996);

      // Reset during SAMPLE of vector 3, with start high on the same edge.
      go(0, ModeAnd, 16'h8000, 0, 16'h0, 1'b0, 5'd0, 1'b0, 4'd0, "rst_mid");
      wait_vec0(4'd3, "rst_mid");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_outputs",
            64'({a0, b0, c0, d0, busy0, done0, tt0, pass0, ec0, fv0, ff0}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start0 = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("rst_mid_still_idle", 64'({busy0, a0, b0, c0, d0}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
